i2c_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one I2C master between NUM_REQ requesters. It latches the winning requester's command and launches the master. It then tracks the transaction to completion, or to timeout, and returns a done or error pulse to the owner. It sits between the system-side command sources and the I2C master's Master_en/R_W_en/Mem_Addr/Data inputs.

---
 rtl/i2c_req_arbiter_pkg.sv | 31 +++
 rtl/i2c_req_arbiter_rr_picker.sv | 33 +++
 rtl/i2c_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_req_arbiter_pkg
// Brief   : Shared types for the I2C requester arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package i2c_req_arbiter_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    RELEASE   = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic     rw;
    address_t addr;
    byte_t    data;
  } i2c_cmd_t;

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin select, search starts after rr_ptr_i.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_req_arbiter
// Brief   : Round-robin sharing of one I2C master with launch/timeout tracking.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  address_t [NUM_REQ-1:0]   req_addr,
  input  byte_t [NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err,
  output logic                     m_en,
  output logic                     m_rw,
  output address_t                 m_addr,
  output byte_t                    m_data,
  input  logic                     m_busy,
  input  logic                     m_done
);

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               m_en_q, m_en_d;
  i2c_cmd_t           cmd_q, cmd_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_valid;
  logic [PTR_W-1:0]   win_idx;
  i2c_cmd_t           win_cmd;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_win),
    .valid_o  (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) begin
        win_idx = PTR_W'(i);
        win_cmd = '{rw: req_rw[i], addr: req_addr[i], data: req_data[i]};
      end
    end
  end

  // done/err are single-cycle pulses, so they default to zero every cycle.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    m_en_d   = m_en_q;
    cmd_d    = cmd_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          cmd_d    = win_cmd;
          gnt_d    = pick_win;
          rr_ptr_d = win_idx;
          state_d  = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        m_en_d  = 1'b1;
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          m_en_d  = 1'b0;
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          m_en_d  = 1'b0;
          err_d   = gnt_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        m_en_d = 1'b0;
        // Completion takes priority over a coincident timeout.
        if (m_done) begin
          done_d  = gnt_q;
          state_d = RELEASE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = gnt_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      m_en_q   <= 1'b0;
      cmd_q    <= '0;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      m_en_q   <= m_en_d;
      cmd_q    <= cmd_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign m_en   = m_en_q;
  assign m_rw   = cmd_q.rw;
  assign m_addr = cmd_q.addr;
  assign m_data = cmd_q.data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_req_arbiter
// Brief   : Directed self-checking bench for i2c_req_arbiter and rr_picker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;
  import i2c_req_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, req_rw;
  address_t [N-1:0] req_addr;
  byte_t [N-1:0]  req_data;
  logic [N-1:0]   gnt, done, err;
  logic           m_en, m_rw;
  address_t       m_addr;
  byte_t          m_data;
  logic           m_busy, m_done;

  logic [3:0]     pk_req;
  logic [1:0]     pk_ptr;
  logic [3:0]     pk_win;
  logic           pk_valid;

  int n_checks = 0;
  int n_fail   = 0;

  address_t addr_tbl [N] = '{7'h50, 7'h21, 7'h32, 7'h43};
  byte_t    data_tbl [N] = '{8'hA5, 8'h11, 8'h22, 8'h33};
  logic     rw_tbl   [N] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .m_en     (m_en),
    .m_rw     (m_rw),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_busy   (m_busy),
    .m_done   (m_done)
  );

  rr_picker #(.NUM_REQ(4)) u_pick (
    .req_i    (pk_req),
    .rr_ptr_i (pk_ptr),
    .winner_o (pk_win),
    .valid_o  (pk_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_fields(input int owner, input string tag);
    check_eq({tag, ".addr"}, 32'(m_addr), 32'(addr_tbl[owner]));
    check_eq({tag, ".data"}, 32'(m_data), 32'(data_tbl[owner]));
    check_eq({tag, ".rw"},   32'(m_rw),   32'(rw_tbl[owner]));
  endtask

  // Called with the arbiter in IDLE and req already driven.
  task automatic launch(input int owner, input string tag);
    tick;
    tick;
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(1 << owner));
    check_fields(owner, tag);
    tick;
    check_eq({tag, ".m_en"}, 32'(m_en), 32'h1);
  endtask

  task automatic finish_ok(input int owner, input int busy_lat, input int done_lat, input string tag);
    repeat (busy_lat) tick;
    check_eq({tag, ".en_hold"}, 32'(m_en), 32'h1);
    m_busy = 1'b1;
    tick;
    check_eq({tag, ".en_off"}, 32'(m_en), 32'h0);
    repeat (done_lat - 1) tick;
    m_done = 1'b1;
    m_busy = 1'b0;
    tick;
    check_eq({tag, ".done"}, 32'(done), 32'(1 << owner));
    check_eq({tag, ".err"},  32'(err),  32'h0);
    check_fields(owner, {tag, ".hold"});
    m_done = 1'b0;
    tick;
    check_eq({tag, ".gnt_clr"},  32'(gnt),  32'h0);
    check_eq({tag, ".done_clr"}, 32'(done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int en_cnt;
    logic [3:0] pv_req [7] = '{4'hF, 4'hF, 4'h9, 4'h1, 4'h0, 4'h6, 4'hC};
    logic [1:0] pv_ptr [7] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3};
    logic [3:0] pv_win [7] = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h0, 4'h2, 4'h4};

    reset_n = 1'b0;
    req     = '0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    pk_req  = '0;
    pk_ptr  = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = addr_tbl[i];
      req_data[i] = data_tbl[i];
      req_rw[i]   = rw_tbl[i];
    end
    tick;
    tick;
    check_eq("rst.gnt",    32'(gnt),    32'h0);
    check_eq("rst.done",   32'(done),   32'h0);
    check_eq("rst.err",    32'(err),    32'h0);
    check_eq("rst.m_en",   32'(m_en),   32'h0);
    check_eq("rst.m_rw",   32'(m_rw),   32'h0);
    check_eq("rst.m_addr", 32'(m_addr), 32'h0);
    check_eq("rst.m_data", 32'(m_data), 32'h0);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      pk_req = pv_req[v];
      pk_ptr = pv_ptr[v];
      #1;
      check_eq($sformatf("pick%0d.win", v),   32'(pk_win),   32'(pv_win[v]));
      check_eq($sformatf("pick%0d.valid", v), 32'(pk_valid), 32'(pv_req[v] != 4'h0));
    end

    // Fairness: all four requesting, order 0,1,2,3,0 from the reset pointer.
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      launch(k % 4, $sformatf("rr%0d", k));
      finish_ok(k % 4, 1, 4, $sformatf("rr%0d", k));
    end
    req = '0;

    // Single write; requester drops req and scrambles inputs after grant.
    req = 4'b0001;
    launch(0, "wr");
    req         = '0;
    req_addr[0] = 7'h7F;
    req_data[0] = 8'h00;
    req_rw[0]   = 1'b1;
    finish_ok(0, 2, 5, "wr");
    req_addr[0] = addr_tbl[0];
    req_data[0] = data_tbl[0];
    req_rw[0]   = rw_tbl[0];

    // Timeout in WAIT_DONE.
    req = 4'b0010;
    launch(1, "tdn");
    tick;
    m_busy = 1'b1;
    tick;
    check_eq("tdn.en_off", 32'(m_en), 32'h0);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (err == '0 && done == '0 && cyc < 40);
    check_eq("tdn.cycles", 32'(cyc),  32'd16);
    check_eq("tdn.err",    32'(err),  32'h2);
    check_eq("tdn.done",   32'(done), 32'h0);
    m_busy = 1'b0;
    req    = '0;
    tick;
    check_eq("tdn.gnt_clr", 32'(gnt), 32'h0);
    check_eq("tdn.err_clr", 32'(err), 32'h0);

    // Timeout in WAIT_BUSY: master never goes busy.
    req = 4'b0100;
    launch(2, "tbz");
    cyc    = 0;
    en_cnt = 1;
    do begin
      tick;
      cyc++;
      if (m_en) en_cnt++;
    end while (err == '0 && cyc < 40);
    check_eq("tbz.cycles", 32'(cyc),    32'd16);
    check_eq("tbz.en_cnt", 32'(en_cnt), 32'd16);
    check_eq("tbz.err",    32'(err),    32'h4);
    check_eq("tbz.m_en",   32'(m_en),   32'h0);
    check_eq("tbz.done",   32'(done),   32'h0);
    req = '0;
    tick;
    check_eq("tbz.gnt_clr", 32'(gnt), 32'h0);

    // m_done arrives on the same cycle the timer hits its terminal value.
    req = 4'b1000;
    launch(3, "sim");
    tick;
    m_busy = 1'b1;
    tick;
    repeat (TMO - 1) tick;
    m_done = 1'b1;
    m_busy = 1'b0;
    tick;
    check_eq("sim.done", 32'(done), 32'h8);
    check_eq("sim.err",  32'(err),  32'h0);
    m_done = 1'b0;
    req    = '0;
    tick;
    check_eq("sim.gnt_clr", 32'(gnt), 32'h0);
    check_eq("sim.err_clr", 32'(err), 32'h0);

    // Asynchronous reset in the middle of WAIT_DONE.
    req = 4'b0010;
    launch(1, "ar");
    tick;
    m_busy = 1'b1;
    tick;
    repeat (3) tick;
    check_eq("ar.gnt_pre", 32'(gnt), 32'h2);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("ar.gnt",    32'(gnt),    32'h0);
    check_eq("ar.m_en",   32'(m_en),   32'h0);
    check_eq("ar.m_rw",   32'(m_rw),   32'h0);
    check_eq("ar.m_addr", 32'(m_addr), 32'h0);
    check_eq("ar.m_data", 32'(m_data), 32'h0);
    check_eq("ar.done",   32'(done),   32'h0);
    check_eq("ar.err",    32'(err),    32'h0);
    m_busy = 1'b0;
    req    = '0;
    tick;
    tick;
    reset_n = 1'b1;
    req = 4'b0100;
    launch(2, "post");
    finish_ok(2, 2, 5, "post");
    req = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
